// File: rtl/cpu_mem_pkg.sv
// Shared types and constants for the fetch / load-store memory port arbiter.
package cpu_mem_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    HOLD_F = 2'd1,
    HOLD_D = 2'd2
  } state_e;

  typedef enum logic {
    OWN_F = 1'b0,
    OWN_D = 1'b1
  } owner_e;

  localparam logic [3:0] BYTE_EN_ALL = 4'hF;

  function automatic owner_e owner_of(input logic sel_d);
    return sel_d ? OWN_D : OWN_F;
  endfunction

endpackage

// File: rtl/arb_pick.sv
// Winner selection between fetch (F) and load/store (D) requesters.
// ARB_ROUND_ROBIN_EN selects round-robin on contention; default is D over F.
module arb_pick
  import cpu_mem_pkg::*;
(
  input  logic   f_req,
  input  logic   d_req,
`ifdef ARB_ROUND_ROBIN_EN
  input  owner_e last_own,
`endif
  output logic   any_req,
  output logic   pick_d
);

  // Combinational winner; a lone requester always wins.
  always_comb begin
    any_req = f_req | d_req;
    pick_d  = 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
    if (f_req && d_req) begin
      pick_d = (last_own == OWN_F);
    end else begin
      pick_d = d_req;
    end
`else
    if (d_req) begin
      pick_d = 1'b1;
    end else begin
      pick_d = 1'b0;
    end
`endif
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch and load/store, with a
// fixed 1-cycle read return. Define ARB_ROUND_ROBIN_EN for round-robin arbitration.
module mem_port_arbiter
  import cpu_mem_pkg::*;
#(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [AW-1:0] i_f_addr,
  input  logic          i_f_rd,
  output logic [DW-1:0] o_f_rddata,
  output logic          o_f_rdvalid,
  output logic          o_f_waitrequest,
  input  logic [AW-1:0] i_d_addr,
  input  logic          i_d_rd,
  input  logic          i_d_wr,
  input  logic [DW-1:0] i_d_wrdata,
  input  logic [3:0]    i_d_byte_en,
  output logic [DW-1:0] o_d_rddata,
  output logic          o_d_rdvalid,
  output logic          o_d_waitrequest,
  output logic [AW-1:0] o_m_addr,
  output logic          o_m_rd,
  output logic          o_m_wr,
  output logic [DW-1:0] o_m_wrdata,
  output logic [3:0]    o_m_byte_en,
  input  logic [DW-1:0] i_m_rddata,
  input  logic          i_m_waitrequest
);

  state_e state_r;
  owner_e owner_r;
  logic   rd_pend_r;
  logic   any_req_s;
  logic   pick_d_s;
  logic   sel_d_s;
  logic   cmd_rd_s;
  logic   cmd_wr_s;
  logic   accept_s;
`ifdef ARB_ROUND_ROBIN_EN
  owner_e rr_r;
`endif

  arb_pick u_arb_pick (
    .f_req    (i_f_rd),
    .d_req    (i_d_rd | i_d_wr),
`ifdef ARB_ROUND_ROBIN_EN
    .last_own (rr_r),
`endif
    .any_req  (any_req_s),
    .pick_d   (pick_d_s)
  );

  // Live pick only in IDLE; a held grant is never re-arbitrated.
  always_comb begin
    sel_d_s = 1'b0;
    case (state_r)
      IDLE:    sel_d_s = pick_d_s;
      HOLD_F:  sel_d_s = 1'b0;
      HOLD_D:  sel_d_s = 1'b1;
      default: sel_d_s = 1'b0;
    endcase
  end

  // Command mux; a simultaneous load+store from D issues only the store.
  always_comb begin
    o_m_addr    = i_f_addr;
    o_m_wrdata  = {DW{1'b0}};
    o_m_byte_en = BYTE_EN_ALL;
    cmd_rd_s    = 1'b0;
    cmd_wr_s    = 1'b0;
    if (sel_d_s) begin
      o_m_addr    = i_d_addr;
      o_m_wrdata  = i_d_wrdata;
      o_m_byte_en = i_d_byte_en;
      cmd_wr_s    = i_d_wr;
      cmd_rd_s    = i_d_rd & ~i_d_wr;
    end else begin
      cmd_rd_s    = i_f_rd;
    end
  end

  assign o_m_rd          = cmd_rd_s & ~reset;
  assign o_m_wr          = cmd_wr_s & ~reset;
  assign accept_s        = (o_m_rd | o_m_wr) & ~i_m_waitrequest;
  assign o_f_waitrequest = ~(accept_s & ~sel_d_s);
  assign o_d_waitrequest = ~(accept_s & sel_d_s);
  assign o_f_rddata      = i_m_rddata;
  assign o_d_rddata      = i_m_rddata;
  assign o_f_rdvalid     = rd_pend_r & (owner_r == OWN_F);
  assign o_d_rdvalid     = rd_pend_r & (owner_r == OWN_D);

  // Grant FSM plus the pending-read/owner tracking for the 1-cycle return.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r   <= IDLE;
      rd_pend_r <= 1'b0;
      owner_r   <= OWN_F;
    end else begin
      rd_pend_r <= accept_s & o_m_rd;
      if (accept_s && o_m_rd) begin
        owner_r <= owner_of(sel_d_s);
      end
      case (state_r)
        IDLE: begin
          if (any_req_s && !accept_s) begin
            state_r <= sel_d_s ? HOLD_D : HOLD_F;
          end
        end
        HOLD_F, HOLD_D: begin
          // Also release if the held requester withdrew, so the port cannot lock up.
          if (accept_s || !(cmd_rd_s || cmd_wr_s)) begin
            state_r <= IDLE;
          end
        end
        default: state_r <= IDLE;
      endcase
    end
  end

`ifdef ARB_ROUND_ROBIN_EN
  // Remember who was granted last so contention alternates.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rr_r <= OWN_F;
    end else if (accept_s) begin
      rr_r <= owner_of(sel_d_s);
    end else begin
      rr_r <= rr_r;
    end
  end
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: per-cycle reference model plus literal checks.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] f_addr, d_addr, d_wrdata, m_rddata;
  logic        f_rd, d_rd, d_wr, m_wait;
  logic [3:0]  d_be;
  logic [31:0] o_f_rddata, o_d_rddata, o_m_addr, o_m_wrdata;
  logic        o_f_rdvalid, o_f_waitrequest, o_d_rdvalid, o_d_waitrequest;
  logic        o_m_rd, o_m_wr;
  logic [3:0]  o_m_byte_en;

  int errors = 0;
  int checks = 0;

  mem_port_arbiter #(.AW(32), .DW(32)) dut (
    .clk(clk), .reset(reset),
    .i_f_addr(f_addr), .i_f_rd(f_rd), .o_f_rddata(o_f_rddata),
    .o_f_rdvalid(o_f_rdvalid), .o_f_waitrequest(o_f_waitrequest),
    .i_d_addr(d_addr), .i_d_rd(d_rd), .i_d_wr(d_wr), .i_d_wrdata(d_wrdata),
    .i_d_byte_en(d_be), .o_d_rddata(o_d_rddata), .o_d_rdvalid(o_d_rdvalid),
    .o_d_waitrequest(o_d_waitrequest),
    .o_m_addr(o_m_addr), .o_m_rd(o_m_rd), .o_m_wr(o_m_wr), .o_m_wrdata(o_m_wrdata),
    .o_m_byte_en(o_m_byte_en), .i_m_rddata(m_rddata), .i_m_waitrequest(m_wait)
  );

  always #5 clk = ~clk;

  task automatic chk32(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk1(input string nm, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: who owns the port (0 none, 1 F, 2 D), who was granted last,
  // who a read is due back to this cycle.
  int held = 0;
  int last_own = 1;
  int ret_own = 0;
  int who_s = 0;
  bit acc_s = 1'b0;
  bit rd_s = 1'b0;

  always @(negedge clk) begin : model_cmp
    int   who;
    logic e_rd, e_wr, acc;
    if (held != 0) who = held;
    else if (f_rd && (d_rd || d_wr)) begin
`ifdef ARB_ROUND_ROBIN_EN
      who = (last_own == 1) ? 2 : 1;
`else
      who = 2;
`endif
    end
    else if (d_rd || d_wr) who = 2;
    else if (f_rd) who = 1;
    else who = 0;
    e_rd = !reset && ((who == 1 && f_rd) || (who == 2 && d_rd && !d_wr));
    e_wr = !reset && who == 2 && d_wr;
    acc  = (e_rd || e_wr) && !m_wait;
    chk1("m_rd", o_m_rd, e_rd);
    chk1("m_wr", o_m_wr, e_wr);
    chk1("f_wait", o_f_waitrequest, !(acc && who == 1));
    chk1("d_wait", o_d_waitrequest, !(acc && who == 2));
    if (who == 1) begin
      chk32("m_addr_f", o_m_addr, f_addr);
      chk32("m_be_f", {28'd0, o_m_byte_en}, 32'h0000000F);
    end
    if (who == 2) begin
      chk32("m_addr_d", o_m_addr, d_addr);
      chk32("m_be_d", {28'd0, o_m_byte_en}, {28'd0, d_be});
    end
    if (e_wr) chk32("m_wrdata", o_m_wrdata, d_wrdata);
    chk1("f_rdvalid", o_f_rdvalid, !reset && ret_own == 1);
    chk1("d_rdvalid", o_d_rdvalid, !reset && ret_own == 2);
    if (!reset && ret_own == 1) chk32("f_rddata", o_f_rddata, m_rddata);
    if (!reset && ret_own == 2) chk32("d_rddata", o_d_rddata, m_rddata);
    who_s <= who;
    acc_s <= acc;
    rd_s  <= e_rd;
  end

  always @(posedge clk) begin : model_upd
    if (reset) begin
      held <= 0; last_own <= 1; ret_own <= 0;
    end else begin
      ret_own <= (acc_s && rd_s) ? who_s : 0;
      if (acc_s) begin
        last_own <= who_s; held <= 0;
      end else begin
        held <= who_s;
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic probe();
    @(negedge clk); #1;
  endtask

  logic [3:0] rr_pat;

  initial begin
    reset = 1'b1; f_rd = 1'b0; d_rd = 1'b0; d_wr = 1'b0; m_wait = 1'b0;
    f_addr = 32'h0; d_addr = 32'h0; d_wrdata = 32'h0; d_be = 4'hF; m_rddata = 32'h0;
`ifdef ARB_ROUND_ROBIN_EN
    rr_pat = 4'b0101;
`else
    rr_pat = 4'b1111;
`endif
    // Reset gating with a live fetch request
    f_rd = 1'b1; f_addr = 32'h10;
    probe(); chk1("rst_m_rd", o_m_rd, 1'b0); chk1("rst_f_rdvalid", o_f_rdvalid, 1'b0);
    tick(); reset = 1'b0; f_rd = 1'b0;
    tick();

    // D load+store together: store only, no rdvalid
    d_rd = 1'b1; d_wr = 1'b1; d_addr = 32'h200; d_wrdata = 32'hA5A5; d_be = 4'h3;
    probe(); chk1("rdwr_wr", o_m_wr, 1'b1); chk1("rdwr_rd", o_m_rd, 1'b0);
    chk32("rdwr_be", {28'd0, o_m_byte_en}, 32'h3);
    tick(); d_rd = 1'b0; d_wr = 1'b0; d_be = 4'hF;
    probe(); chk1("rdwr_no_rdvalid", o_d_rdvalid, 1'b0);
    tick();

    // Lone fetch read, 1-cycle return
    f_rd = 1'b1; f_addr = 32'h10;
    probe(); chk1("s1_m_rd", o_m_rd, 1'b1); chk32("s1_addr", o_m_addr, 32'h10);
    chk32("s1_be", {28'd0, o_m_byte_en}, 32'hF); chk1("s1_f_wait", o_f_waitrequest, 1'b0);
    tick(); f_rd = 1'b0; m_rddata = 32'hDEADBEEF;
    probe(); chk1("s1_f_rdvalid", o_f_rdvalid, 1'b1); chk32("s1_f_rddata", o_f_rddata, 32'hDEADBEEF);
    chk1("s1_d_rdvalid", o_d_rdvalid, 1'b0);
    tick(); m_rddata = 32'h12345678;
    probe(); chk1("s1_pulse_once", o_f_rdvalid, 1'b0); chk1("s1_idle_rd", o_m_rd, 1'b0);
    tick();

    // Contention: D store first, F read next cycle
    f_rd = 1'b1; f_addr = 32'h20; d_wr = 1'b1; d_addr = 32'h100; d_wrdata = 32'h55;
    probe(); chk1("s2_wr", o_m_wr, 1'b1); chk32("s2_addr_d", o_m_addr, 32'h100);
    chk32("s2_wrdata", o_m_wrdata, 32'h55); chk1("s2_f_stall", o_f_waitrequest, 1'b1);
    chk1("s2_d_go", o_d_waitrequest, 1'b0);
    tick(); d_wr = 1'b0;
    probe(); chk1("s2_f_rd", o_m_rd, 1'b1); chk32("s2_addr_f", o_m_addr, 32'h20);
    chk1("s2_f_go", o_f_waitrequest, 1'b0);
    tick(); f_rd = 1'b0; m_rddata = 32'hCAFE0020;
    probe(); chk1("s2_f_rdvalid", o_f_rdvalid, 1'b1);
    tick();

    // D read stalled 3 cycles while F waits, then back-to-back F read
    d_rd = 1'b1; d_addr = 32'h40; f_rd = 1'b1; f_addr = 32'h30; m_wait = 1'b1;
    for (int i = 0; i < 3; i++) begin
      probe(); chk32("s3_hold_addr", o_m_addr, 32'h40); chk1("s3_f_stall", o_f_waitrequest, 1'b1);
      chk1("s3_d_stall", o_d_waitrequest, 1'b1);
      tick();
    end
    m_wait = 1'b0;
    probe(); chk32("s3_acc_addr", o_m_addr, 32'h40); chk1("s3_d_go", o_d_waitrequest, 1'b0);
    tick(); d_rd = 1'b0; m_rddata = 32'h0BAD0040;
    probe(); chk1("s3_d_rdvalid", o_d_rdvalid, 1'b1); chk32("s3_d_rddata", o_d_rddata, 32'h0BAD0040);
    chk32("s3_f_addr", o_m_addr, 32'h30); chk1("s3_f_go", o_f_waitrequest, 1'b0);
    tick(); f_rd = 1'b0; m_rddata = 32'h00000030;
    probe(); chk1("s3_f_rdvalid", o_f_rdvalid, 1'b1); chk1("s3_d_quiet", o_d_rdvalid, 1'b0);
    tick();

    // Reset right after a fetch read is accepted: the return is dropped
    f_rd = 1'b1; f_addr = 32'h44;
    probe(); chk1("s4_acc", o_f_waitrequest, 1'b0);
    tick(); reset = 1'b1;
    probe(); chk1("s4_no_rdvalid", o_f_rdvalid, 1'b0); chk1("s4_rst_rd", o_m_rd, 1'b0);
    tick(); reset = 1'b0; f_addr = 32'h48;
    probe(); chk1("s4_idle_grant", o_f_waitrequest, 1'b0); chk1("s4_idle_rd", o_m_rd, 1'b1);
    tick(); f_rd = 1'b0; m_rddata = 32'h00000048;
    probe(); chk1("s4_new_rdvalid", o_f_rdvalid, 1'b1);
    tick();

    // F, D, F reads back to back
    f_rd = 1'b1; f_addr = 32'h50;
    probe(); chk1("s5_f1", o_m_rd, 1'b1);
    tick(); f_rd = 1'b0; d_rd = 1'b1; d_addr = 32'h60; m_rddata = 32'h11111111;
    probe(); chk1("s5_rv_f1", o_f_rdvalid, 1'b1); chk32("s5_data_f1", o_f_rddata, 32'h11111111);
    chk1("s5_d_go", o_d_waitrequest, 1'b0);
    tick(); d_rd = 1'b0; f_rd = 1'b1; f_addr = 32'h70; m_rddata = 32'h22222222;
    probe(); chk1("s5_rv_d", o_d_rdvalid, 1'b1); chk32("s5_data_d", o_d_rddata, 32'h22222222);
    chk1("s5_rv_f_quiet", o_f_rdvalid, 1'b0);
    tick(); f_rd = 1'b0; m_rddata = 32'h33333333;
    probe(); chk1("s5_rv_f2", o_f_rdvalid, 1'b1); chk32("s5_data_f2", o_f_rddata, 32'h33333333);
    tick();

    // Continuous contention after reset: D,F,D,F round-robin or all D fixed
    reset = 1'b1; tick(); reset = 1'b0;
    d_rd = 1'b1; d_addr = 32'h80; f_rd = 1'b1; f_addr = 32'h90;
    for (int i = 0; i < 4; i++) begin
      probe();
      chk1("s6_d_grant", !o_d_waitrequest, rr_pat[i]);
      chk1("s6_f_grant", !o_f_waitrequest, !rr_pat[i]);
      m_rddata = 32'hA0 + 32'(i);
      tick();
    end
    d_rd = 1'b0; f_rd = 1'b0;
    tick(); tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 SHALL have parameter: AW, 32, address width.
REQ-002 SHALL have parameter: DW, 32, data width.
REQ-003 SHALL have ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high.
- i_f_addr  in  AW  fetch address.
- i_f_rd  in  1  fetch read request.
- o_f_rddata  out  DW  fetch read data.
- o_f_rdvalid  out  1  fetch read data valid.
- o_f_waitrequest  out  1  fetch stall.
- i_d_addr  in  AW  load/store address.
- i_d_rd  in  1  load request.
- i_d_wr  in  1  store request.
- i_d_wrdata  in  DW  store data.
- i_d_byte_en  in  4  store/load byte enables.
- o_d_rddata  out  DW  load read data.
- o_d_rdvalid  out  1  load read data valid.
- o_d_waitrequest  out  1  load/store stall.
- o_m_addr  out  AW  memory address.
- o_m_rd  out  1  memory read.
- o_m_wr  out  1  memory write.
- o_m_wrdata  out  DW  memory write data.
- o_m_byte_en  out  4  memory byte enables.
- i_m_rddata  in  DW  memory read data.
- i_m_waitrequest  in  1  memory stall.

Function
REQ-004 SHALL share one memory port between fetch (F) and load/store (D) requesters.
REQ-005 SHALL implement FSM states IDLE, HOLD_F, HOLD_D.
REQ-006 In IDLE, SHALL pick a winner combinationally in the same cycle and drive o_m_* from that winner; a one-requester cycle grants that requester.
REQ-007 SHALL treat a command as accepted when o_m_rd or o_m_wr is high and i_m_waitrequest is low.
REQ-008 If the winner's command is not accepted, SHALL move to HOLD_F or HOLD_D and keep that grant until acceptance; no re-arbitration while held.
REQ-009 On acceptance, SHALL return to IDLE, or stay in IDLE if already there.
REQ-010 SHALL set o_x_waitrequest low only for the granted requester in the acceptance cycle; it SHALL be high otherwise while that requester asserts a request.
REQ-011 Fetch commands SHALL drive o_m_byte_en = 4'hF and o_m_wr = 0.
REQ-012 If i_d_rd and i_d_wr are both high, SHALL issue a write only.
REQ-013 Memory read latency is fixed at 1 cycle after acceptance.
REQ-014 SHALL register a pending-read valid bit and an owner bit at read acceptance.
REQ-015 In the next cycle, SHALL route i_m_rddata to the owner's o_x_rddata and pulse that owner's o_x_rdvalid for exactly 1 cycle.
REQ-016 Writes SHALL produce no rdvalid.
REQ-017 Back-to-back reads SHALL be supported: a new command may be accepted in the same cycle a previous read returns, giving one read per cycle at full throughput.
REQ-018 o_f_rddata and o_d_rddata SHALL both carry i_m_rddata; only rdvalid qualifies them.
REQ-019 With no request pending, SHALL drive o_m_rd = o_m_wr = 0.

Reset
REQ-020 On reset assertion, SHALL immediately set: state IDLE, pending-read bit 0, owner F, round-robin pointer F, o_f_rdvalid = 0, o_d_rdvalid = 0.
REQ-021 An in-flight read interrupted by reset SHALL never produce rdvalid.
REQ-022 SHALL hold o_m_rd = 0 and o_m_wr = 0 while reset is high.

Configuration
REQ-023 With ARB_ROUND_ROBIN_EN defined: on simultaneous F and D requests in IDLE, SHALL grant the requester not granted last; the pointer updates on each acceptance.
REQ-024 Without ARB_ROUND_ROBIN_EN: fixed priority, D over F; no pointer register.

Structure
REQ-025 Package cpu_mem_pkg SHALL hold: state enum (IDLE, HOLD_F, HOLD_D), owner enum (OWN_F, OWN_D), and constant BYTE_EN_ALL = 4'hF.
REQ-026 Sub-module arb_pick SHALL contain the winner selection (fixed-priority or round-robin), instantiated once.

Verification
REQ-027 F read addr 0x10 alone, waitrequest 0 -> o_m_rd=1, o_m_addr=0x10, o_m_byte_en=F same cycle; next cycle i_m_rddata 0xDEADBEEF -> o_f_rdvalid=1, o_f_rddata=0xDEADBEEF, o_d_rdvalid=0.
REQ-028 F rd 0x20 and D wr 0x100 data 0x55 same cycle, fixed priority -> D write accepted first with o_f_waitrequest=1; F read accepted next cycle.
REQ-029 With ARB_ROUND_ROBIN_EN, both requesting continuously for 4 cycles -> grant order D,F,D,F (after reset pointer F).
REQ-030 D read 0x40 with i_m_waitrequest high 3 cycles while F requests -> state HOLD_D, o_m_addr stays 0x40 all 3 cycles, F stalled; D rdvalid 1 cycle after acceptance.
REQ-031 F read accepted, reset pulsed the next cycle -> no o_f_rdvalid, state IDLE, o_m_rd=0 during reset.
REQ-032 Consecutive F read, D read, F read with no stalls -> rdvalid pulses alternate F, D, F on consecutive cycles, each with correct data.
